snd_dma_seq: RTL and testbench

DMA sound frame sequencer for the MCU.
- Owns the sound word-address counter and the frame start/end shadow registers.
- Requests memory slots from the bus slot scheduler and tracks sample-FIFO occupancy.
- Handles frame end, repeat and stop, and produces the frame-end interrupt pulse.
- Sits between the CPU-visible sound control/frame registers, the bus cycle scheduler (grants) and the sound output shifter (pops).

---
 rtl/snd_pkg.sv | 15 +
 rtl/snd_fifo_cnt.sv | 59 +++++
 rtl/snd_dma_seq.sv | 142 ++++++++++++++
 tb/tb_snd_dma_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared types and defaults for the DMA sound frame sequencer.
package snd_pkg;

    localparam int SND_AW         = 21;
    localparam int SND_FIFO_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        RELOAD = 3'd3,
        DRAIN  = 3'd4
    } snd_state_t;

endpackage

// File: rtl/snd_fifo_cnt.sv
// Sample-FIFO occupancy counter with sticky underrun detection.
module snd_fifo_cnt #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          porb,
    input  logic          clr,
    input  logic          uclr,
    input  logic          inc,
    input  logic          dec,
    output logic [LW-1:0] lvl,
    output logic          full,
    output logic          empty,
    output logic          underrun
);

    logic [LW-1:0] lvl_q, lvl_d;
    logic          unr_q, unr_d;

    assign lvl      = lvl_q;
    assign full     = (lvl_q == LW'(DEPTH));
    assign empty    = (lvl_q == {LW{1'b0}});
    assign underrun = unr_q;

    // next level and underrun flag; a same-cycle write and pop cancel out
    always_comb begin
        lvl_d = lvl_q;
        unr_d = unr_q;
        if (clr) begin
            lvl_d = {LW{1'b0}};
        end else if (inc && !dec) begin
            lvl_d = lvl_q + LW'(1);
        end else if (dec && !inc && !empty) begin
            lvl_d = lvl_q - LW'(1);
        end else begin
            lvl_d = lvl_q;
        end
        if (uclr) begin
            unr_d = 1'b0;
        end else if (dec && !inc && empty) begin
            unr_d = 1'b1;
        end else begin
            unr_d = unr_q;
        end
    end

    // occupancy registers
    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            lvl_q <= {LW{1'b0}};
            unr_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            unr_q <= unr_d;
        end
    end

endmodule

// File: rtl/snd_dma_seq.sv
// DMA sound frame sequencer: address counter, frame shadow registers,
// slot requests, repeat/stop handling and the frame-end interrupt.
module snd_dma_seq
    import snd_pkg::*;
#(
    parameter int AW         = SND_AW,
    parameter int FIFO_WORDS = SND_FIFO_WORDS,
    localparam int LW        = $clog2(FIFO_WORDS + 1)
) (
    input  logic          clk,
    input  logic          porb,
    input  logic          sndon,
    input  logic          sfrep,
    input  logic [AW-1:0] frm_start,
    input  logic [AW-1:0] frm_end,
    input  logic          sgrant,
    input  logic          spop,
    output logic          sreq,
    output logic [AW-1:0] snd_addr,
    output logic          sint,
    output logic          sactive,
    output logic [LW-1:0] fifo_lvl,
    output logic          underrun
);

    snd_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] shadow_end_q, shadow_end_d;
    logic          sint_q, sint_d;
    logic          sactive_q, sactive_d;

    logic [AW-1:0] addr_inc;
    logic          grant_acc;
    logic          frame_done;
    logic          frame_empty;
    logic          fifo_clr;
    logic          fifo_full;
    logic          fifo_empty;

    assign sreq     = (state_q == RUN) && !fifo_full;
    assign snd_addr = addr_q;
    assign sint     = sint_q;
    assign sactive  = sactive_q;

    snd_fifo_cnt #(
        .DEPTH (FIFO_WORDS),
        .LW    (LW)
    ) u_fifo_cnt (
        .clk      (clk),
        .porb     (porb),
        .clr      (fifo_clr),
        .uclr     (!sndon),
        .inc      (grant_acc),
        .dec      (spop),
        .lvl      (fifo_lvl),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .underrun (underrun)
    );

    // next-state logic; dropping sndon outside IDLE aborts and discards any grant
    always_comb begin
        addr_inc     = addr_q + AW'(1);
        grant_acc    = sreq && sgrant && sndon;
        frame_done   = grant_acc && (addr_inc == shadow_end_q);
        frame_empty  = (frm_start == frm_end);
        state_d      = state_q;
        addr_d       = addr_q;
        shadow_end_d = shadow_end_q;
        sint_d       = 1'b0;
        fifo_clr     = 1'b0;
        if ((state_q != IDLE) && !sndon) begin
            state_d  = IDLE;
            fifo_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sndon) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD, RELOAD: begin
                    addr_d       = frm_start;
                    shadow_end_d = frm_end;
                    fifo_clr     = (state_q == LOAD);
                    // an empty-frame repeat loop must still leave gaps between pulses
                    if (frame_empty) begin
                        sint_d  = !sint_q;
                        state_d = sfrep ? RELOAD : IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (grant_acc) begin
                        addr_d = addr_inc;
                    end else begin
                        addr_d = addr_q;
                    end
                    if (frame_done) begin
                        sint_d  = 1'b1;
                        state_d = sfrep ? RELOAD : DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    fifo_clr = 1'b1;
                end
            endcase
        end
        sactive_d = (state_d != IDLE);
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            state_q      <= IDLE;
            addr_q       <= {AW{1'b0}};
            shadow_end_q <= {AW{1'b0}};
            sint_q       <= 1'b0;
            sactive_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            shadow_end_q <= shadow_end_d;
            sint_q       <= sint_d;
            sactive_q    <= sactive_d;
        end
    end

endmodule

// File: tb/tb_snd_dma_seq.sv
// Directed, table-driven self-checking bench for snd_dma_seq.
module tb_snd_dma_seq;

    logic        clk;
    logic        porb;
    logic        sndon;
    logic        sfrep;
    logic [20:0] frm_start;
    logic [20:0] frm_end;
    logic        sgrant;
    logic        spop;
    logic        sreq;
    logic [20:0] snd_addr;
    logic        sint;
    logic        sactive;
    logic [2:0]  fifo_lvl;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        on;
        logic        rep;
        logic [20:0] fs;
        logic [20:0] fe;
        logic        g;
        logic        p;
        logic        e_sreq;
        logic [20:0] e_addr;
        logic        e_sint;
        logic        e_sact;
        logic [2:0]  e_lvl;
        logic        e_unr;
    } vec_t;

    vec_t vt [28];

    snd_dma_seq dut (
        .clk       (clk),
        .porb      (porb),
        .sndon     (sndon),
        .sfrep     (sfrep),
        .frm_start (frm_start),
        .frm_end   (frm_end),
        .sgrant    (sgrant),
        .spop      (spop),
        .sreq      (sreq),
        .snd_addr  (snd_addr),
        .sint      (sint),
        .sactive   (sactive),
        .fifo_lvl  (fifo_lvl),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic on, input logic rep, input logic [20:0] fs,
                                input logic [20:0] fe, input logic g, input logic p,
                                input logic e_sreq, input logic [20:0] e_addr,
                                input logic e_sint, input logic e_sact,
                                input logic [2:0] e_lvl, input logic e_unr);
        vec_t v;
        v.on = on; v.rep = rep; v.fs = fs; v.fe = fe; v.g = g; v.p = p;
        v.e_sreq = e_sreq; v.e_addr = e_addr; v.e_sint = e_sint;
        v.e_sact = e_sact; v.e_lvl = e_lvl; v.e_unr = e_unr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_sreq, input logic [20:0] e_addr,
                           input logic e_sint, input logic e_sact,
                           input logic [2:0] e_lvl, input logic e_unr);
        chk({tag, ".sreq"},     32'(sreq),     32'(e_sreq));
        chk({tag, ".addr"},     32'(snd_addr), 32'(e_addr));
        chk({tag, ".sint"},     32'(sint),     32'(e_sint));
        chk({tag, ".sactive"},  32'(sactive),  32'(e_sact));
        chk({tag, ".lvl"},      32'(fifo_lvl), 32'(e_lvl));
        chk({tag, ".underrun"}, 32'(underrun), 32'(e_unr));
    endtask

    task automatic drive(input logic on, input logic rep, input logic [20:0] fs,
                         input logic [20:0] fe, input logic g, input logic p);
        sndon = on; sfrep = rep; frm_start = fs; frm_end = fe; sgrant = g; spop = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // basic frame 0x100..0x104, no repeat, then drain
        vt[0]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b0, 1'b0, 1'b0, 21'h000, 1'b0, 1'b1, 3'd0, 1'b0);
        vt[1]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b0, 1'b0, 1'b1, 21'h100, 1'b0, 1'b1, 3'd0, 1'b0);
        vt[2]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b1, 1'b0, 1'b1, 21'h101, 1'b0, 1'b1, 3'd1, 1'b0);
        vt[3]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b1, 1'b0, 1'b1, 21'h102, 1'b0, 1'b1, 3'd2, 1'b0);
        vt[4]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b1, 1'b1, 1'b1, 21'h103, 1'b0, 1'b1, 3'd2, 1'b0);
        vt[5]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b1, 1'b0, 1'b0, 21'h104, 1'b1, 1'b1, 3'd3, 1'b0);
        vt[6]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b0, 1'b0, 1'b0, 21'h104, 1'b0, 1'b1, 3'd3, 1'b0);
        vt[7]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b0, 1'b1, 1'b0, 21'h104, 1'b0, 1'b1, 3'd2, 1'b0);
        vt[8]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b0, 1'b1, 1'b0, 21'h104, 1'b0, 1'b1, 3'd1, 1'b0);
        vt[9]  = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b1, 1'b0, 1'b0, 21'h104, 1'b0, 1'b1, 3'd1, 1'b0);
        vt[10] = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b0, 1'b1, 1'b0, 21'h104, 1'b0, 1'b1, 3'd0, 1'b0);
        vt[11] = mk(1'b1, 1'b0, 21'h100, 21'h104, 1'b0, 1'b0, 1'b0, 21'h104, 1'b0, 1'b0, 3'd0, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 21'h100, 21'h104, 1'b0, 1'b0, 1'b0, 21'h104, 1'b0, 1'b0, 3'd0, 1'b0);
        // full FIFO, ignored grants, pop reopens request, then underrun
        vt[13] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b0, 1'b0, 21'h104, 1'b0, 1'b1, 3'd0, 1'b0);
        vt[14] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b0, 1'b1, 21'h010, 1'b0, 1'b1, 3'd0, 1'b0);
        vt[15] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b1, 1'b0, 1'b1, 21'h011, 1'b0, 1'b1, 3'd1, 1'b0);
        vt[16] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b1, 1'b0, 1'b1, 21'h012, 1'b0, 1'b1, 3'd2, 1'b0);
        vt[17] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b1, 1'b0, 1'b1, 21'h013, 1'b0, 1'b1, 3'd3, 1'b0);
        vt[18] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b1, 1'b0, 1'b0, 21'h014, 1'b0, 1'b1, 3'd4, 1'b0);
        vt[19] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b1, 1'b0, 1'b0, 21'h014, 1'b0, 1'b1, 3'd4, 1'b0);
        vt[20] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b1, 1'b1, 21'h014, 1'b0, 1'b1, 3'd3, 1'b0);
        vt[21] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b1, 1'b1, 1'b1, 21'h015, 1'b0, 1'b1, 3'd3, 1'b0);
        vt[22] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b1, 1'b1, 21'h015, 1'b0, 1'b1, 3'd2, 1'b0);
        vt[23] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b1, 1'b1, 21'h015, 1'b0, 1'b1, 3'd1, 1'b0);
        vt[24] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b1, 1'b1, 21'h015, 1'b0, 1'b1, 3'd0, 1'b0);
        vt[25] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b1, 1'b1, 21'h015, 1'b0, 1'b1, 3'd0, 1'b1);
        vt[26] = mk(1'b1, 1'b0, 21'h010, 21'h020, 1'b0, 1'b0, 1'b1, 21'h015, 1'b0, 1'b1, 3'd0, 1'b1);
        vt[27] = mk(1'b0, 1'b0, 21'h010, 21'h020, 1'b0, 1'b0, 1'b0, 21'h015, 1'b0, 1'b0, 3'd0, 1'b0);

        porb = 1'b0;
        drive(1'b0, 1'b0, 21'h0, 21'h0, 1'b0, 1'b0);
        #2;
        chk_all("reset", 1'b0, 21'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        porb = 1'b1;
        tick();
        chk_all("idle", 1'b0, 21'h0, 1'b0, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 28; i++) begin
            drive(vt[i].on, vt[i].rep, vt[i].fs, vt[i].fe, vt[i].g, vt[i].p);
            tick();
            chk_all($sformatf("v%0d", i), vt[i].e_sreq, vt[i].e_addr, vt[i].e_sint,
                    vt[i].e_sact, vt[i].e_lvl, vt[i].e_unr);
        end

        // repeat: registers rewritten mid-frame take effect at the next frame
        drive(1'b1, 1'b1, 21'h200, 21'h202, 1'b0, 1'b0); tick();
        chk_all("rep.load", 1'b0, 21'h015, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        chk_all("rep.run", 1'b1, 21'h200, 1'b0, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 1'b1, 21'h300, 21'h301, 1'b1, 1'b0); tick();
        chk_all("rep.g1", 1'b1, 21'h201, 1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        chk_all("rep.end1", 1'b0, 21'h202, 1'b1, 1'b1, 3'd2, 1'b0);
        sgrant = 1'b0; tick();
        chk_all("rep.reload1", 1'b1, 21'h300, 1'b0, 1'b1, 3'd2, 1'b0);
        sgrant = 1'b1; tick();
        chk_all("rep.end2", 1'b0, 21'h301, 1'b1, 1'b1, 3'd3, 1'b0);
        sgrant = 1'b0; tick();
        chk_all("rep.reload2", 1'b1, 21'h300, 1'b0, 1'b1, 3'd3, 1'b0);

        // abort at lvl 3 with a simultaneous grant
        sndon = 1'b0; sgrant = 1'b1; tick();
        chk_all("abort", 1'b0, 21'h300, 1'b0, 1'b0, 3'd0, 1'b0);

        // empty frame without repeat
        drive(1'b1, 1'b0, 21'h050, 21'h050, 1'b0, 1'b0); tick();
        chk_all("empty.load", 1'b0, 21'h300, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        chk_all("empty.sint", 1'b0, 21'h050, 1'b1, 1'b0, 3'd0, 1'b0);
        sndon = 1'b0; tick();
        chk_all("empty.idle", 1'b0, 21'h050, 1'b0, 1'b0, 3'd0, 1'b0);

        // frame wrapping through 2^21
        drive(1'b1, 1'b0, 21'h1FFFFE, 21'h000001, 1'b0, 1'b0); tick();
        chk_all("wrap.load", 1'b0, 21'h050, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        chk_all("wrap.run", 1'b1, 21'h1FFFFE, 1'b0, 1'b1, 3'd0, 1'b0);
        sgrant = 1'b1; tick();
        chk_all("wrap.g1", 1'b1, 21'h1FFFFF, 1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        chk_all("wrap.g2", 1'b1, 21'h000000, 1'b0, 1'b1, 3'd2, 1'b0);
        tick();
        chk_all("wrap.end", 1'b0, 21'h000001, 1'b1, 1'b1, 3'd3, 1'b0);
        sgrant = 1'b0; sndon = 1'b0; tick();
        chk_all("wrap.stop", 1'b0, 21'h000001, 1'b0, 1'b0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
